// File: rtl/reorder_buffer_pkg.sv
// Shared constants for the reorder buffer: sizing, field widths and instruction ids.
// Ids are grouped so loads, stores, branches, upper/jump and ALU ops form contiguous ranges.
package reorder_buffer_pkg;

   localparam int unsigned ROBSize      = 16;
   localparam int unsigned ROBIdxWidth  = 4;
   localparam int unsigned InstrIdWidth = 6;
   localparam int unsigned RegIdxWidth  = 5;
   localparam int unsigned DataWidth    = 32;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;
   localparam logic [DataWidth-1:0] ZERO = '0;

   localparam logic [InstrIdWidth-1:0] LB    = 6'd0;
   localparam logic [InstrIdWidth-1:0] LH    = 6'd1;
   localparam logic [InstrIdWidth-1:0] LW    = 6'd2;
   localparam logic [InstrIdWidth-1:0] LBU   = 6'd3;
   localparam logic [InstrIdWidth-1:0] LHU   = 6'd4;
   localparam logic [InstrIdWidth-1:0] SB    = 6'd5;
   localparam logic [InstrIdWidth-1:0] SH    = 6'd6;
   localparam logic [InstrIdWidth-1:0] SW    = 6'd7;
   localparam logic [InstrIdWidth-1:0] BEQ   = 6'd8;
   localparam logic [InstrIdWidth-1:0] BNE   = 6'd9;
   localparam logic [InstrIdWidth-1:0] BLT   = 6'd10;
   localparam logic [InstrIdWidth-1:0] BGE   = 6'd11;
   localparam logic [InstrIdWidth-1:0] BLTU  = 6'd12;
   localparam logic [InstrIdWidth-1:0] BGEU  = 6'd13;
   localparam logic [InstrIdWidth-1:0] LUI   = 6'd14;
   localparam logic [InstrIdWidth-1:0] AUIPC = 6'd15;
   localparam logic [InstrIdWidth-1:0] JAL   = 6'd16;
   localparam logic [InstrIdWidth-1:0] JALR  = 6'd17;
   localparam logic [InstrIdWidth-1:0] ADDI  = 6'd18;
   localparam logic [InstrIdWidth-1:0] ADD   = 6'd27;
   localparam logic [InstrIdWidth-1:0] SUB   = 6'd28;

endpackage

// File: rtl/reorder_buffer_commit_decode.sv
// Classifies the retiring instruction: does it write the register file, is it a store.
module reorder_buffer_commit_decode
   import reorder_buffer_pkg::*;
(
   input  logic [InstrIdWidth-1:0] instr_id_i,
   input  logic [RegIdxWidth-1:0]  rd_i,
   output logic                    regfile_we_o,
   output logic                    store_o
);

   always_comb begin
      regfile_we_o = FALSE;
      store_o      = FALSE;
      if ((instr_id_i <= LHU) || ((instr_id_i >= LUI) && (instr_id_i <= JALR)) ||
          (instr_id_i >= ADDI)) begin
         regfile_we_o = (rd_i != '0);
      end
      if ((instr_id_i >= SB) && (instr_id_i <= SW)) begin
         store_o = TRUE;
      end
   end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order issue at tail, out-of-order CDB writeback, in-order
// retirement at head, with a full pipeline flush when a mispredicted control op retires.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int unsigned ROBSize     = reorder_buffer_pkg::ROBSize,
   parameter int unsigned ROBIdxWidth = reorder_buffer_pkg::ROBIdxWidth
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    rdy_in,
   input  logic                    issue_en_in,
   input  logic [InstrIdWidth-1:0] issue_instr_id_in,
   input  logic [RegIdxWidth-1:0]  issue_rd_in,
   input  logic                    alu_cdb_en_in,
   input  logic [ROBIdxWidth-1:0]  alu_cdb_idx_in,
   input  logic [DataWidth-1:0]    alu_cdb_val_in,
   input  logic                    alu_cdb_mispred_in,
   input  logic [DataWidth-1:0]    alu_cdb_target_in,
   input  logic                    lsb_cdb_en_in,
   input  logic [ROBIdxWidth-1:0]  lsb_cdb_idx_in,
   input  logic [DataWidth-1:0]    lsb_cdb_val_in,
   input  logic [ROBIdxWidth-1:0]  query1_idx_in,
   input  logic [ROBIdxWidth-1:0]  query2_idx_in,
   output logic                    query1_ready_out,
   output logic [DataWidth-1:0]    query1_val_out,
   output logic                    query2_ready_out,
   output logic [DataWidth-1:0]    query2_val_out,
   output logic                    rob_empty_out,
   output logic [ROBIdxWidth-1:0]  rob_head_out,
   output logic [ROBIdxWidth-1:0]  rob_tail_out,
   output logic                    commit_regfile_en_out,
   output logic [RegIdxWidth-1:0]  commit_rd_out,
   output logic [DataWidth-1:0]    commit_val_out,
   output logic [ROBIdxWidth-1:0]  commit_idx_out,
   output logic                    commit_lsb_en_out,
   output logic                    flush_out,
   output logic [DataWidth-1:0]    flush_pc_out
);

   logic [ROBSize-1:0]      busy_q;
   logic [ROBSize-1:0]      ready_q;
   logic [ROBSize-1:0]      mispred_q;
   logic [InstrIdWidth-1:0] instr_id_q [ROBSize];
   logic [RegIdxWidth-1:0]  rd_q       [ROBSize];
   logic [DataWidth-1:0]    val_q      [ROBSize];
   logic [DataWidth-1:0]    target_q   [ROBSize];

   logic [ROBIdxWidth-1:0]  head_q, tail_q, head_inc;
   logic                    empty_q;

   logic                    regfile_en_q, lsb_en_q, flush_q;
   logic [RegIdxWidth-1:0]  commit_rd_q;
   logic [DataWidth-1:0]    commit_val_q, flush_pc_q;
   logic [ROBIdxWidth-1:0]  commit_idx_q;

   logic                    alu_hit, lsb_hit;
   logic                    head_ready, head_mispred;
   logic [DataWidth-1:0]    head_val, head_target;
   logic                    do_commit, do_flush, do_issue;
   logic                    dec_regfile_we, dec_store;

   // A frozen cycle ignores the buses entirely, including for bypass.
   assign alu_hit  = rdy_in && alu_cdb_en_in;
   assign lsb_hit  = rdy_in && lsb_cdb_en_in;
   assign head_inc = head_q + 1'b1;

   function automatic logic [DataWidth:0] lookup(input logic [ROBIdxWidth-1:0] idx);
      lookup = {FALSE, ZERO};
      if (ready_q[idx]) lookup = {TRUE, val_q[idx]};
      if (alu_hit && (alu_cdb_idx_in == idx)) lookup = {TRUE, alu_cdb_val_in};
      if (lsb_hit && (lsb_cdb_idx_in == idx)) lookup = {TRUE, lsb_cdb_val_in};
   endfunction

   always_comb begin
      {query1_ready_out, query1_val_out} = lookup(query1_idx_in);
      {query2_ready_out, query2_val_out} = lookup(query2_idx_in);
   end

   // Head view with same-cycle CDB bypass so a result can retire the cycle it arrives.
   always_comb begin
      head_ready   = ready_q[head_q];
      head_val     = val_q[head_q];
      head_mispred = mispred_q[head_q];
      head_target  = target_q[head_q];
      if (alu_hit && (alu_cdb_idx_in == head_q)) begin
         head_ready   = TRUE;
         head_val     = alu_cdb_val_in;
         head_mispred = alu_cdb_mispred_in;
         head_target  = alu_cdb_target_in;
      end
      if (lsb_hit && (lsb_cdb_idx_in == head_q)) begin
         head_ready = TRUE;
         head_val   = lsb_cdb_val_in;
      end
      do_commit = rdy_in && !empty_q && busy_q[head_q] && head_ready;
      do_flush  = do_commit && head_mispred;
      do_issue  = rdy_in && issue_en_in && !do_flush;
   end

   reorder_buffer_commit_decode u_commit_decode (
      .instr_id_i   (instr_id_q[head_q]),
      .rd_i         (rd_q[head_q]),
      .regfile_we_o (dec_regfile_we),
      .store_o      (dec_store)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head_q       <= '0;
         tail_q       <= '0;
         empty_q      <= TRUE;
         busy_q       <= '0;
         ready_q      <= '0;
         mispred_q    <= '0;
         regfile_en_q <= FALSE;
         lsb_en_q     <= FALSE;
         flush_q      <= FALSE;
         commit_rd_q  <= '0;
         commit_val_q <= ZERO;
         commit_idx_q <= '0;
         flush_pc_q   <= ZERO;
         for (int i = 0; i < ROBSize; i++) begin
            instr_id_q[i] <= '0;
            rd_q[i]       <= '0;
            val_q[i]      <= ZERO;
            target_q[i]   <= ZERO;
         end
      end else if (!rdy_in) begin
         regfile_en_q <= FALSE;
         lsb_en_q     <= FALSE;
         flush_q      <= FALSE;
      end else begin
         regfile_en_q <= do_commit && dec_regfile_we;
         lsb_en_q     <= do_commit && dec_store;
         flush_q      <= do_flush;
         if (do_commit) begin
            commit_rd_q  <= rd_q[head_q];
            commit_val_q <= head_val;
            commit_idx_q <= head_q;
         end
         if (do_flush) begin
            flush_pc_q <= head_target;
            head_q     <= '0;
            tail_q     <= '0;
            empty_q    <= TRUE;
            busy_q     <= '0;
         end else begin
            if (alu_hit) begin
               ready_q[alu_cdb_idx_in]   <= TRUE;
               val_q[alu_cdb_idx_in]     <= alu_cdb_val_in;
               mispred_q[alu_cdb_idx_in] <= alu_cdb_mispred_in;
               target_q[alu_cdb_idx_in]  <= alu_cdb_target_in;
            end
            if (lsb_hit) begin
               ready_q[lsb_cdb_idx_in] <= TRUE;
               val_q[lsb_cdb_idx_in]   <= lsb_cdb_val_in;
            end
            if (do_commit) begin
               busy_q[head_q] <= FALSE;
               head_q         <= head_inc;
            end
            // Issue is last so a slot freed by this cycle's commit is overwritten cleanly.
            if (do_issue) begin
               busy_q[tail_q]     <= TRUE;
               ready_q[tail_q]    <= FALSE;
               mispred_q[tail_q]  <= FALSE;
               instr_id_q[tail_q] <= issue_instr_id_in;
               rd_q[tail_q]       <= issue_rd_in;
               tail_q             <= tail_q + 1'b1;
               empty_q            <= FALSE;
            end else if (do_commit && (head_inc == tail_q)) begin
               empty_q <= TRUE;
            end
         end
      end
   end

   assign rob_empty_out         = empty_q;
   assign rob_head_out          = head_q;
   assign rob_tail_out          = tail_q;
   assign commit_regfile_en_out = regfile_en_q;
   assign commit_rd_out         = commit_rd_q;
   assign commit_val_out        = commit_val_q;
   assign commit_idx_out        = commit_idx_q;
   assign commit_lsb_en_out     = lsb_en_q;
   assign flush_out             = flush_q;
   assign flush_pc_out          = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic against an occupancy-count
// model that treats the buffer as a program-order window over a slot array.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   logic        clk = 1'b0;
   logic        rst, rdy, issue_en, alu_en, alu_mp, lsb_en;
   logic [5:0]  issue_id;
   logic [4:0]  issue_rd;
   logic [3:0]  alu_idx, lsb_idx, q1_idx, q2_idx;
   logic [31:0] alu_val, alu_tgt, lsb_val;
   logic        q1_rdy, q2_rdy, empty, rf_en, lsb_commit, flush;
   logic [31:0] q1_val, q2_val, c_val, f_pc;
   logic [3:0]  head, tail, c_idx;
   logic [4:0]  c_rd;

   always #5 clk = ~clk;

   reorder_buffer dut (
      .clk_in                (clk),
      .rst_in                (rst),
      .rdy_in                (rdy),
      .issue_en_in           (issue_en),
      .issue_instr_id_in     (issue_id),
      .issue_rd_in           (issue_rd),
      .alu_cdb_en_in         (alu_en),
      .alu_cdb_idx_in        (alu_idx),
      .alu_cdb_val_in        (alu_val),
      .alu_cdb_mispred_in    (alu_mp),
      .alu_cdb_target_in     (alu_tgt),
      .lsb_cdb_en_in         (lsb_en),
      .lsb_cdb_idx_in        (lsb_idx),
      .lsb_cdb_val_in        (lsb_val),
      .query1_idx_in         (q1_idx),
      .query2_idx_in         (q2_idx),
      .query1_ready_out      (q1_rdy),
      .query1_val_out        (q1_val),
      .query2_ready_out      (q2_rdy),
      .query2_val_out        (q2_val),
      .rob_empty_out         (empty),
      .rob_head_out          (head),
      .rob_tail_out          (tail),
      .commit_regfile_en_out (rf_en),
      .commit_rd_out         (c_rd),
      .commit_val_out        (c_val),
      .commit_idx_out        (c_idx),
      .commit_lsb_en_out     (lsb_commit),
      .flush_out             (flush),
      .flush_pc_out          (f_pc)
   );

   int n_checks = 0;
   int n_bad    = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Model: slots plus a window [m_head, m_head+m_count) in program order.
   int          m_head, m_count;
   bit          m_ready [ROBSize];
   bit          m_mp    [ROBSize];
   logic [31:0] m_val   [ROBSize];
   logic [31:0] m_tgt   [ROBSize];
   int          m_id    [ROBSize];
   int          m_rd    [ROBSize];
   bit          e_rf, e_lsb, e_fl;
   int          e_rd, e_idx;
   logic [31:0] e_val, e_fpc;

   function automatic bit is_store(input int id);
      return id >= int'(SB) && id <= int'(SW);
   endfunction

   function automatic bit is_branch(input int id);
      return id >= int'(BEQ) && id <= int'(BGEU);
   endfunction

   function automatic logic [32:0] model_query(input logic [3:0] idx);
      logic [32:0] r;
      r = {1'b0, 32'd0};
      if (m_ready[idx]) r = {1'b1, m_val[idx]};
      if (rdy && alu_en && alu_idx == idx) r = {1'b1, alu_val};
      if (rdy && lsb_en && lsb_idx == idx) r = {1'b1, lsb_val};
      return r;
   endfunction

   task automatic model_step();
      int          t;
      bit          hv, hmp, commit;
      logic [31:0] hval, htgt;
      if (rst) begin
         m_head = 0; m_count = 0;
         for (int k = 0; k < ROBSize; k++) begin
            m_ready[k] = 0; m_mp[k] = 0; m_val[k] = 0; m_tgt[k] = 0; m_id[k] = 0; m_rd[k] = 0;
         end
         e_rf = 0; e_lsb = 0; e_fl = 0; e_rd = 0; e_idx = 0; e_val = 0; e_fpc = 0;
      end else if (!rdy) begin
         e_rf = 0; e_lsb = 0; e_fl = 0;
      end else begin
         t = (m_head + m_count) % ROBSize;
         hv = m_ready[m_head]; hval = m_val[m_head]; hmp = m_mp[m_head]; htgt = m_tgt[m_head];
         if (alu_en && int'(alu_idx) == m_head) begin
            hv = 1; hval = alu_val; hmp = alu_mp; htgt = alu_tgt;
         end
         if (lsb_en && int'(lsb_idx) == m_head) begin
            hv = 1; hval = lsb_val;
         end
         commit = (m_count > 0) && hv;
         e_rf  = commit && !is_store(m_id[m_head]) && !is_branch(m_id[m_head]) &&
                 m_rd[m_head] != 0;
         e_lsb = commit && is_store(m_id[m_head]);
         e_fl  = commit && hmp;
         if (commit) begin
            e_rd = m_rd[m_head]; e_val = hval; e_idx = m_head;
         end
         if (e_fl) begin
            e_fpc = htgt; m_head = 0; m_count = 0;
         end else begin
            if (alu_en) begin
               m_ready[alu_idx] = 1; m_val[alu_idx] = alu_val;
               m_mp[alu_idx] = alu_mp; m_tgt[alu_idx] = alu_tgt;
            end
            if (lsb_en) begin
               m_ready[lsb_idx] = 1; m_val[lsb_idx] = lsb_val;
            end
            if (commit) begin
               m_head = (m_head + 1) % ROBSize; m_count--;
            end
            if (issue_en) begin
               m_ready[t] = 0; m_mp[t] = 0; m_id[t] = issue_id; m_rd[t] = issue_rd; m_count++;
            end
         end
      end
   endtask

   task automatic tick();
      logic [32:0] q;
      if (!rst) begin
         #1;
         q = model_query(q1_idx);
         check_eq("q1_ready", 32'(q1_rdy), 32'(q[32]));
         check_eq("q1_val", q1_val, q[31:0]);
         q = model_query(q2_idx);
         check_eq("q2_ready", 32'(q2_rdy), 32'(q[32]));
         check_eq("q2_val", q2_val, q[31:0]);
      end
      model_step();
      @(posedge clk);
      #1;
      check_eq("empty", 32'(empty), 32'(m_count == 0));
      check_eq("head", 32'(head), 32'(m_head));
      check_eq("tail", 32'(tail), 32'((m_head + m_count) % ROBSize));
      check_eq("rf_en", 32'(rf_en), 32'(e_rf));
      check_eq("lsb_en", 32'(lsb_commit), 32'(e_lsb));
      check_eq("flush", 32'(flush), 32'(e_fl));
      check_eq("c_rd", 32'(c_rd), 32'(e_rd));
      check_eq("c_val", c_val, e_val);
      check_eq("c_idx", 32'(c_idx), 32'(e_idx));
      check_eq("flush_pc", f_pc, e_fpc);
   endtask

   task automatic clear_inputs();
      rst = 0; rdy = 1; issue_en = 0; issue_id = 0; issue_rd = 0;
      alu_en = 0; alu_idx = 0; alu_val = 0; alu_mp = 0; alu_tgt = 0;
      lsb_en = 0; lsb_idx = 0; lsb_val = 0; q1_idx = 0; q2_idx = 0;
   endtask

   task automatic do_reset();
      clear_inputs(); rst = 1; tick(); tick();
      clear_inputs();
   endtask

   task automatic issue(input logic [5:0] id, input logic [4:0] rd);
      clear_inputs(); issue_en = 1; issue_id = id; issue_rd = rd; tick();
   endtask

   task automatic alu_wb(input int idx, input logic [31:0] v);
      clear_inputs(); alu_en = 1; alu_idx = 4'(idx); alu_val = v; tick();
   endtask

   function automatic int pick_idx();
      if (m_count == 0) return int'($urandom_range(0, ROBSize - 1));
      return (m_head + int'($urandom_range(0, m_count - 1))) % ROBSize;
   endfunction

   initial begin
      // Reset and fill with 16 ADDIs.
      do_reset();
      check_eq("rst_empty", 32'(empty), 32'd1);
      check_eq("rst_head", 32'(head), 32'd0);
      check_eq("rst_tail", 32'(tail), 32'd0);
      check_eq("rst_flush", 32'(flush), 32'd0);
      for (int i = 0; i < 16; i++) issue(ADDI, 5'(i + 1));
      check_eq("full_empty", 32'(empty), 32'd0);
      check_eq("full_head", 32'(head), 32'd0);
      check_eq("full_tail", 32'(tail), 32'd0);

      // Out-of-order writeback, in-order retirement.
      alu_wb(1, 32'h111);
      check_eq("ooo_no_commit", 32'(rf_en), 32'd0);
      alu_wb(0, 32'h100);
      check_eq("ooo_c0_en", 32'(rf_en), 32'd1);
      check_eq("ooo_c0_idx", 32'(c_idx), 32'd0);
      check_eq("ooo_c0_rd", 32'(c_rd), 32'd1);
      check_eq("ooo_c0_val", c_val, 32'h100);
      clear_inputs(); tick();
      check_eq("ooo_c1_idx", 32'(c_idx), 32'd1);
      check_eq("ooo_c1_rd", 32'(c_rd), 32'd2);
      check_eq("ooo_c1_val", c_val, 32'h111);

      // Frozen cycle: CDB ignored, state held.
      clear_inputs(); rdy = 0; alu_en = 1; alu_idx = 4'd2; alu_val = 32'h222; tick();
      check_eq("frz_no_commit", 32'(rf_en), 32'd0);
      check_eq("frz_head", 32'(head), 32'd2);
      clear_inputs(); tick();
      check_eq("frz_cdb_dropped", 32'(rf_en), 32'd0);

      // Store retirement.
      do_reset();
      issue(ADDI, 5'd3); issue(ADDI, 5'd4); issue(ADDI, 5'd5); issue(SW, 5'd0);
      alu_wb(0, 32'h1); alu_wb(1, 32'h2); alu_wb(2, 32'h3);
      clear_inputs(); lsb_en = 1; lsb_idx = 4'd3; lsb_val = 32'h44; tick();
      check_eq("sw_lsb_en", 32'(lsb_commit), 32'd1);
      check_eq("sw_rf_en", 32'(rf_en), 32'd0);
      check_eq("sw_idx", 32'(c_idx), 32'd3);

      // Mispredicted branch retires while an issue is attempted.
      do_reset();
      issue(ADDI, 5'd1); issue(ADDI, 5'd2); issue(BEQ, 5'd0);
      alu_wb(0, 32'h10); alu_wb(1, 32'h20);
      clear_inputs(); alu_en = 1; alu_idx = 4'd2; alu_mp = 1; alu_tgt = 32'h1000;
      issue_en = 1; issue_id = ADDI; issue_rd = 5'd9; tick();
      check_eq("br_flush", 32'(flush), 32'd1);
      check_eq("br_pc", f_pc, 32'h1000);
      check_eq("br_empty", 32'(empty), 32'd1);
      check_eq("br_head", 32'(head), 32'd0);
      check_eq("br_tail", 32'(tail), 32'd0);
      clear_inputs(); tick();
      check_eq("br_flush_pulse", 32'(flush), 32'd0);

      // Both buses hit the same entry: LSB wins for query and commit.
      do_reset();
      for (int i = 0; i < 6; i++) issue(ADDI, 5'(i + 1));
      clear_inputs(); alu_en = 1; alu_idx = 4'd5; alu_val = 32'hA;
      lsb_en = 1; lsb_idx = 4'd5; lsb_val = 32'hB; q1_idx = 4'd5;
      #1;
      check_eq("dual_q_ready", 32'(q1_rdy), 32'd1);
      check_eq("dual_q_val", q1_val, 32'hB);
      tick();
      for (int i = 0; i < 5; i++) alu_wb(i, 32'(i));
      clear_inputs(); tick();
      check_eq("dual_c_idx", 32'(c_idx), 32'd5);
      check_eq("dual_c_val", c_val, 32'hB);

      // Wrap-around and rd=0 commit.
      do_reset();
      for (int i = 0; i < 15; i++) issue(ADDI, 5'd7);
      check_eq("wrap_tail15", 32'(tail), 32'd15);
      for (int i = 0; i < 15; i++) alu_wb(i, 32'(i + 100));
      issue(ADD, 5'd0);
      check_eq("wrap_tail0", 32'(tail), 32'd0);
      alu_wb(15, 32'h55);
      check_eq("wrap_rd0_rf", 32'(rf_en), 32'd0);
      check_eq("wrap_c_idx", 32'(c_idx), 32'd15);
      check_eq("wrap_head0", 32'(head), 32'd0);

      // Issue and commit together while full.
      do_reset();
      for (int i = 0; i < 16; i++) issue(ADDI, 5'd3);
      clear_inputs(); alu_en = 1; alu_idx = 4'd0; alu_val = 32'h77;
      issue_en = 1; issue_id = ADDI; issue_rd = 5'd20; tick();
      check_eq("fullx_rf", 32'(rf_en), 32'd1);
      check_eq("fullx_head", 32'(head), 32'd1);
      check_eq("fullx_tail", 32'(tail), 32'd1);
      check_eq("fullx_empty", 32'(empty), 32'd0);

      // Random traffic.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         clear_inputs();
         rst = ($urandom_range(0, 199) == 0);
         rdy = ($urandom_range(0, 9) != 0);
         if (m_count < ROBSize && $urandom_range(0, 1) == 1) begin
            issue_en = 1;
            issue_id = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 36));
            issue_rd = 5'($urandom);
         end
         if ($urandom_range(0, 2) != 0) begin
            alu_en = 1; alu_idx = 4'(pick_idx()); alu_val = $urandom;
            alu_mp = ($urandom_range(0, 7) == 0); alu_tgt = $urandom;
         end
         if ($urandom_range(0, 2) == 0) begin
            lsb_en = 1; lsb_idx = 4'(pick_idx()); lsb_val = $urandom;
         end
         q1_idx = 4'($urandom); q2_idx = 4'(pick_idx());
         tick();
      end

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
